// File: rtl/elixirchip_es1_spu_op_mac.sv
// ---------------------------------------------------------------------------
// elixirchip_es1_spu_op_mac
//   Pipelined multiply-accumulate operator. Each operand may be signed or
//   unsigned. A running accumulator is started by s_first and zeroed by
//   s_clear. The accumulator is shifted right arithmetically, then narrowed to
//   M_DATA_BITS with either saturation or wrap. m_sat flags any out-of-range
//   result. The result is emitted on every valid beat.
//
//   Ports
//     clk       in   clock
//     reset     in   asynchronous active-high reset, clears all state
//     cke       in   clock enable; every register holds while low
//     s_data0   in   multiplicand (S_DATA0_BITS)
//     s_data1   in   multiplier   (S_DATA1_BITS)
//     s_first   in   first beat of a sum: load the product instead of adding it
//     s_clear   in   clear beat: output CLEAR_DATA, zero the accumulator
//     s_valid   in   input beat valid
//     m_data    out  signed result (M_DATA_BITS)
//     m_sat     out  result was clamped / truncation lost significant bits
//     m_valid   out  m_data / m_sat valid
// ---------------------------------------------------------------------------
module elixirchip_es1_spu_op_mac #(
    parameter int                     LATENCY      = 4,
    parameter int                     S_DATA0_BITS = 8,
    parameter int                     S_DATA1_BITS = 8,
    parameter int                     DATA0_SIGNED = 1,
    parameter int                     DATA1_SIGNED = 0,
    parameter int                     ACC_BITS     = 24,
    parameter int                     M_DATA_BITS  = 16,
    parameter int                     DATA_SHIFT   = 0,
    parameter int                     SATURATE     = 1,
    parameter logic [M_DATA_BITS-1:0] CLEAR_DATA   = '0,
    parameter int                     USE_CLEAR    = 0,
    parameter int                     USE_VALID    = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cke,
    input  logic [S_DATA0_BITS-1:0]       s_data0,
    input  logic [S_DATA1_BITS-1:0]       s_data1,
    input  logic                          s_first,
    input  logic                          s_clear,
    input  logic                          s_valid,
    output logic signed [M_DATA_BITS-1:0] m_data,
    output logic                          m_sat,
    output logic                          m_valid
);

    localparam int P_BITS = S_DATA0_BITS + S_DATA1_BITS + 1;

    generate
        if (LATENCY < 4) begin : g_bad_latency
            $error("elixirchip_es1_spu_op_mac: LATENCY must be >= 4");
        end
        if (ACC_BITS < P_BITS) begin : g_bad_acc
            $error("elixirchip_es1_spu_op_mac: ACC_BITS must be >= S_DATA0_BITS+S_DATA1_BITS+1");
        end
    endgenerate

    logic w_clear;
    logic w_valid;
    assign w_clear = s_clear & (USE_CLEAR != 0);
    assign w_valid = s_valid | (USE_VALID == 0);

    // Stage 0: input capture
    logic [S_DATA0_BITS-1:0] r_s0_data0;
    logic [S_DATA1_BITS-1:0] r_s0_data1;
    logic                    r_s0_first, r_s0_clear, r_s0_valid;

    // Stage 1: product
    logic signed [P_BITS-1:0] w_op0, w_op1, w_prod;
    logic signed [P_BITS-1:0] r_s1_prod;
    logic                     r_s1_first, r_s1_clear, r_s1_valid;

    // Stage 2: accumulator
    logic signed [ACC_BITS-1:0] w_prod_ext;
    logic signed [ACC_BITS-1:0] r_acc;
    logic                       r_s2_clear, r_s2_valid;

    // Stage 3: shift and narrow
    logic signed [ACC_BITS-1:0]          w_shift;
    logic [ACC_BITS-M_DATA_BITS:0]       w_hi;
    logic                                w_ovf;
    logic [M_DATA_BITS-1:0]              w_bound;
    logic [M_DATA_BITS-1:0]              r_s3_data;
    logic                                r_s3_sat, r_s3_valid;

    // Extending both operands into the full product width makes the signed
    // multiply exact for every signedness combination.
    assign w_op0 = (DATA0_SIGNED != 0) ? P_BITS'($signed(r_s0_data0)) : P_BITS'(r_s0_data0);
    assign w_op1 = (DATA1_SIGNED != 0) ? P_BITS'($signed(r_s0_data1)) : P_BITS'(r_s0_data1);
    assign w_prod = w_op0 * w_op1;

    assign w_prod_ext = ACC_BITS'(r_s1_prod);

    assign w_shift = r_acc >>> DATA_SHIFT;
    // In range exactly when every bit from the output sign bit upward agrees.
    assign w_hi    = w_shift[ACC_BITS-1:M_DATA_BITS-1];
    assign w_ovf   = !((&w_hi) || !(|w_hi));
    assign w_bound = w_shift[ACC_BITS-1] ? {1'b1, {(M_DATA_BITS-1){1'b0}}}
                                         : {1'b0, {(M_DATA_BITS-1){1'b1}}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s0_data0 <= '0;
            r_s0_data1 <= '0;
            r_s0_first <= 1'b0;
            r_s0_clear <= 1'b0;
            r_s0_valid <= 1'b0;
            r_s1_prod  <= '0;
            r_s1_first <= 1'b0;
            r_s1_clear <= 1'b0;
            r_s1_valid <= 1'b0;
            r_acc      <= '0;
            r_s2_clear <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_data  <= '0;
            r_s3_sat   <= 1'b0;
            r_s3_valid <= 1'b0;
        end else if (cke) begin
            r_s0_data0 <= s_data0;
            r_s0_data1 <= s_data1;
            r_s0_first <= s_first;
            r_s0_clear <= w_clear;
            r_s0_valid <= w_valid;

            r_s1_prod  <= w_prod;
            r_s1_first <= r_s0_first;
            r_s1_clear <= r_s0_clear;
            r_s1_valid <= r_s0_valid;

            if (r_s1_valid) begin
                if (r_s1_clear) begin
                    r_acc <= '0;
                end else if (r_s1_first) begin
                    r_acc <= w_prod_ext;
                end else begin
                    r_acc <= r_acc + w_prod_ext;
                end
            end
            r_s2_clear <= r_s1_clear;
            r_s2_valid <= r_s1_valid;

            if (r_s2_valid) begin
                if (r_s2_clear) begin
                    r_s3_data <= CLEAR_DATA;
                    r_s3_sat  <= 1'b0;
                end else if (w_ovf) begin
                    r_s3_data <= (SATURATE != 0) ? w_bound : w_shift[M_DATA_BITS-1:0];
                    r_s3_sat  <= 1'b1;
                end else begin
                    r_s3_data <= w_shift[M_DATA_BITS-1:0];
                    r_s3_sat  <= 1'b0;
                end
            end
            r_s3_valid <= r_s2_valid;
        end
    end

    generate
        if (LATENCY > 4) begin : g_delay
            localparam int unsigned N = LATENCY - 4;
            logic [M_DATA_BITS-1:0] r_dl_data  [N];
            logic                   r_dl_sat   [N];
            logic                   r_dl_valid [N];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int unsigned i = 0; i < N; i++) begin
                        r_dl_data[i]  <= '0;
                        r_dl_sat[i]   <= 1'b0;
                        r_dl_valid[i] <= 1'b0;
                    end
                end else if (cke) begin
                    r_dl_valid[0] <= r_s3_valid;
                    if (r_s3_valid) begin
                        r_dl_data[0] <= r_s3_data;
                        r_dl_sat[0]  <= r_s3_sat;
                    end
                    for (int unsigned i = 1; i < N; i++) begin
                        r_dl_valid[i] <= r_dl_valid[i-1];
                        if (r_dl_valid[i-1]) begin
                            r_dl_data[i] <= r_dl_data[i-1];
                            r_dl_sat[i]  <= r_dl_sat[i-1];
                        end
                    end
                end
            end

            assign m_data  = r_dl_data[N-1];
            assign m_sat   = r_dl_sat[N-1];
            assign m_valid = r_dl_valid[N-1];
        end else begin : g_direct
            assign m_data  = r_s3_data;
            assign m_sat   = r_s3_sat;
            assign m_valid = r_s3_valid;
        end
    endgenerate

endmodule

// File: tb/tb_elixirchip_es1_spu_op_mac.sv
// ---------------------------------------------------------------------------
// tb_elixirchip_es1_spu_op_mac
//   Six differently configured instances share one input stream. A queue-based
//   model predicts every output; directed anchors pin the worked examples.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_elixirchip_es1_spu_op_mac;

    localparam int NI = 6;
    localparam int          C_LAT  [NI] = '{4, 4, 4, 4, 4, 6};
    localparam int          C_S0   [NI] = '{1, 1, 0, 0, 1, 1};
    localparam int          C_S1   [NI] = '{0, 0, 0, 0, 1, 1};
    localparam int          C_SH   [NI] = '{0, 0, 0, 1, 0, 0};
    localparam int          C_SAT  [NI] = '{1, 0, 1, 1, 1, 0};
    localparam int          C_UCLR [NI] = '{0, 0, 0, 0, 1, 1};
    localparam int          C_UVAL [NI] = '{0, 0, 0, 0, 1, 1};
    localparam logic [15:0] C_CLR  [NI] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 16'h1234};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cke = 1'b0;
    logic [7:0] s_data0 = '0;
    logic [7:0] s_data1 = '0;
    logic       s_first = 1'b0;
    logic       s_clear = 1'b0;
    logic       s_valid = 1'b0;

    logic signed [15:0] md [NI];
    logic               ms [NI];
    logic               mv [NI];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        elixirchip_es1_spu_op_mac #(
            .LATENCY      (C_LAT[g]),
            .S_DATA0_BITS (8),
            .S_DATA1_BITS (8),
            .DATA0_SIGNED (C_S0[g]),
            .DATA1_SIGNED (C_S1[g]),
            .ACC_BITS     (24),
            .M_DATA_BITS  (16),
            .DATA_SHIFT   (C_SH[g]),
            .SATURATE     (C_SAT[g]),
            .CLEAR_DATA   (C_CLR[g]),
            .USE_CLEAR    (C_UCLR[g]),
            .USE_VALID    (C_UVAL[g])
        ) u_dut (
            .clk     (clk),
            .reset   (reset),
            .cke     (cke),
            .s_data0 (s_data0),
            .s_data1 (s_data1),
            .s_first (s_first),
            .s_clear (s_clear),
            .s_valid (s_valid),
            .m_data  (md[g]),
            .m_sat   (ms[g]),
            .m_valid (mv[g])
        );
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [15:0] d;
        logic        s;
        logic        v;
    } res_t;

    res_t   pipe [NI][$];
    res_t   expv [NI];
    res_t   last [NI];
    longint acc  [NI];

    function automatic longint wrap24(input longint x);
        longint t;
        t = x & 64'h0000_0000_00FF_FFFF;
        if (t >= 64'h0000_0000_0080_0000) t = t - 64'h0000_0000_0100_0000;
        return t;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < NI; u++) begin
            acc[u]  = 0;
            last[u] = '0;
            expv[u] = '0;
            pipe[u].delete();
            for (int k = 0; k < C_LAT[u] - 1; k++) pipe[u].push_back('0);
        end
    endtask

    task automatic model_beat(input logic first, input logic clear, input logic valid,
                              input logic [7:0] d0, input logic [7:0] d1);
        for (int u = 0; u < NI; u++) begin
            longint a, b, sh;
            res_t   r;
            bit     eclr, evld;
            eclr = clear && (C_UCLR[u] != 0);
            evld = valid || (C_UVAL[u] == 0);
            if (!evld) begin
                r   = last[u];
                r.v = 1'b0;
            end else begin
                if (C_S0[u] != 0) a = longint'($signed(d0)); else a = longint'(d0);
                if (C_S1[u] != 0) b = longint'($signed(d1)); else b = longint'(d1);
                if (eclr)       acc[u] = 0;
                else if (first) acc[u] = a * b;
                else            acc[u] = wrap24(acc[u] + a * b);
                if (eclr) begin
                    r.d = C_CLR[u];
                    r.s = 1'b0;
                end else begin
                    sh = acc[u] >>> C_SH[u];
                    if (sh > 32767) begin
                        r.d = (C_SAT[u] != 0) ? 16'h7FFF : sh[15:0];
                        r.s = 1'b1;
                    end else if (sh < -32768) begin
                        r.d = (C_SAT[u] != 0) ? 16'h8000 : sh[15:0];
                        r.s = 1'b1;
                    end else begin
                        r.d = sh[15:0];
                        r.s = 1'b0;
                    end
                end
                r.v = 1'b1;
                last[u] = r;
            end
            pipe[u].push_back(r);
            expv[u] = pipe[u].pop_front();
        end
    endtask

    // One clock: drive at the falling edge, advance the model for enabled
    // edges, return 1 ns after the rising edge.
    task automatic cycle(input logic c, input logic f, input logic cl, input logic v,
                         input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        cke = c; s_first = f; s_clear = cl; s_valid = v; s_data0 = a; s_data1 = b;
        if (c && !reset) model_beat(f, cl, v, a, b);
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        model_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'd7, 8'd9);
            for (int u = 0; u < NI; u++) begin
                checks++;
                if ({md[u], ms[u], mv[u]} !== 18'd0) begin
                    errors++;
                    $display("FAIL reset u%0d: got d=%0d s=%0b v=%0b want 0/0/0", u, md[u], ms[u], mv[u]);
                end
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_signed_unsigned();
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h80, 8'hFF);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h80, 8'hFF);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            for (int u = 0; u < NI; u++) begin
                checks++;
                if ({md[u], ms[u], mv[u]} !== {expv[u].d, expv[u].s, expv[u].v}) begin
                    errors++;
                    $display("FAIL su_model u%0d: got d=%0d s=%0b v=%0b want d=%0d s=%0b v=%0b",
                             u, md[u], ms[u], mv[u], $signed(expv[u].d), expv[u].s, expv[u].v);
                end
            end
            if (k == 1) begin
                checks++;
                if ({md[0], ms[0], mv[0]} !== {16'sd32768 - 16'sd65408, 1'b0, 1'b1}) begin
                    errors++;
                    $display("FAIL su_first: got d=%0d s=%0b want d=-32640 s=0", md[0], ms[0]);
                end
            end
            if (k == 2) begin
                checks++;
                if ({md[0], ms[0]} !== {16'h8000, 1'b1}) begin
                    errors++;
                    $display("FAIL su_sat: got d=%0d s=%0b want d=-32768 s=1", md[0], ms[0]);
                end
                checks++;
                if ({md[1], ms[1]} !== {16'h0100, 1'b1}) begin
                    errors++;
                    $display("FAIL su_wrap: got d=%0d s=%0b want d=256 s=1", md[1], ms[1]);
                end
            end
        end
    endtask

    task automatic test_unsigned_shift();
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            for (int u = 0; u < NI; u++) begin
                checks++;
                if ({md[u], ms[u], mv[u]} !== {expv[u].d, expv[u].s, expv[u].v}) begin
                    errors++;
                    $display("FAIL uu_model u%0d: got d=%0d s=%0b v=%0b want d=%0d s=%0b v=%0b",
                             u, md[u], ms[u], mv[u], $signed(expv[u].d), expv[u].s, expv[u].v);
                end
            end
            if (k == 2) begin
                checks++;
                if ({md[2], ms[2]} !== {16'd32767, 1'b1}) begin
                    errors++;
                    $display("FAIL uu_sat: got d=%0d s=%0b want d=32767 s=1", md[2], ms[2]);
                end
                checks++;
                if ({md[3], ms[3]} !== {16'd32512, 1'b0}) begin
                    errors++;
                    $display("FAIL uu_shift: got d=%0d s=%0b want d=32512 s=0", md[3], ms[3]);
                end
            end
        end
    endtask

    task automatic test_valid_gap();
        for (int i = 1; i <= 10; i++) begin
            if (i == 1)      cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'd3, 8'hFE);
            else if (i == 5) cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'd3, 8'hFE);
            else             cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'($urandom), 8'($urandom));
            for (int u = 0; u < NI; u++) begin
                checks++;
                if ({md[u], ms[u], mv[u]} !== {expv[u].d, expv[u].s, expv[u].v}) begin
                    errors++;
                    $display("FAIL gap_model u%0d i%0d: got d=%0d s=%0b v=%0b want d=%0d s=%0b v=%0b",
                             u, i, md[u], ms[u], mv[u], $signed(expv[u].d), expv[u].s, expv[u].v);
                end
            end
            if (i >= 4 && i <= 7) begin
                checks++;
                if ({md[4], mv[4]} !== {16'hFFFA, (i == 4)}) begin
                    errors++;
                    $display("FAIL gap_hold i%0d: got d=%0d v=%0b want d=-6 v=%0b", i, md[4], mv[4], (i == 4));
                end
            end
            if (i == 8) begin
                checks++;
                if ({md[4], mv[4]} !== {16'hFFF4, 1'b1}) begin
                    errors++;
                    $display("FAIL gap_sum: got d=%0d v=%0b want d=-12 v=1", md[4], mv[4]);
                end
            end
        end
    endtask

    task automatic test_clear();
        logic [15:0] want [4];
        want = '{16'd100, 16'd200, 16'h7FFF, 16'd1};
        for (int i = 1; i <= 9; i++) begin
            case (i)
                1:       cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'd10, 8'd10);
                2:       cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'd10, 8'd10);
                3:       cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'd5, 8'd5);
                4:       cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 8'd1);
                default: cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
            endcase
            for (int u = 0; u < NI; u++) begin
                checks++;
                if ({md[u], ms[u], mv[u]} !== {expv[u].d, expv[u].s, expv[u].v}) begin
                    errors++;
                    $display("FAIL clr_model u%0d i%0d: got d=%0d s=%0b v=%0b want d=%0d s=%0b v=%0b",
                             u, i, md[u], ms[u], mv[u], $signed(expv[u].d), expv[u].s, expv[u].v);
                end
            end
            if (i >= 4 && i <= 7) begin
                checks++;
                if ({md[4], ms[4], mv[4]} !== {want[i-4], 1'b0, 1'b1}) begin
                    errors++;
                    $display("FAIL clr_seq i%0d: got d=%0h s=%0b v=%0b want d=%0h s=0 v=1",
                             i, md[4], ms[4], mv[4], want[i-4]);
                end
            end
        end
    endtask

    task automatic test_cke_and_reset();
        for (int i = 1; i <= 16; i++) begin
            cycle((i != 7 && i != 8), (i == 1), 1'b0, 1'b1, 8'($urandom), 8'($urandom));
            for (int u = 0; u < NI; u++) begin
                checks++;
                if ({md[u], ms[u], mv[u]} !== {expv[u].d, expv[u].s, expv[u].v}) begin
                    errors++;
                    $display("FAIL cke_model u%0d i%0d: got d=%0d s=%0b v=%0b want d=%0d s=%0b v=%0b",
                             u, i, md[u], ms[u], mv[u], $signed(expv[u].d), expv[u].s, expv[u].v);
                end
            end
        end
        // asynchronous reset in the middle of a sum
        reset = 1'b1;
        #1;
        for (int u = 0; u < NI; u++) begin
            checks++;
            if ({md[u], ms[u], mv[u]} !== 18'd0) begin
                errors++;
                $display("FAIL async_reset u%0d: got d=%0d s=%0b v=%0b want 0/0/0", u, md[u], ms[u], mv[u]);
            end
        end
        model_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'd9, 8'd9);
        reset = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'd2, 8'd3);
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
            for (int u = 0; u < NI; u++) begin
                checks++;
                if ({md[u], ms[u], mv[u]} !== {expv[u].d, expv[u].s, expv[u].v}) begin
                    errors++;
                    $display("FAIL post_reset_model u%0d k%0d: got d=%0d s=%0b v=%0b want d=%0d s=%0b v=%0b",
                             u, k, md[u], ms[u], mv[u], $signed(expv[u].d), expv[u].s, expv[u].v);
                end
            end
            if (k == 4) begin
                checks++;
                if ({md[5], ms[5], mv[5]} !== {16'd6, 1'b0, 1'b1}) begin
                    errors++;
                    $display("FAIL post_reset_sum: got d=%0d s=%0b v=%0b want d=6 s=0 v=1", md[5], ms[5], mv[5]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic signed [15:0] prod_q [$];
        logic signed [15:0] want;
        logic [7:0] a, b;
        for (int i = 1; i <= 26; i++) begin
            if (i <= 20) begin
                a = 8'($urandom);
                b = 8'($urandom);
                prod_q.push_back(16'($signed({a[7], a}) * $signed({1'b0, b})));
                cycle(1'b1, 1'b1, 1'b0, 1'b1, a, b);
            end else begin
                cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
            end
            for (int u = 0; u < NI; u++) begin
                checks++;
                if ({md[u], ms[u], mv[u]} !== {expv[u].d, expv[u].s, expv[u].v}) begin
                    errors++;
                    $display("FAIL b2b_model u%0d i%0d: got d=%0d s=%0b v=%0b want d=%0d s=%0b v=%0b",
                             u, i, md[u], ms[u], mv[u], $signed(expv[u].d), expv[u].s, expv[u].v);
                end
            end
            if (i >= 4 && i <= 23) begin
                want = prod_q.pop_front();
                checks++;
                if ({md[0], ms[0]} !== {want, 1'b0}) begin
                    errors++;
                    $display("FAIL b2b_product i%0d: got d=%0d s=%0b want d=%0d s=0", i, md[0], ms[0], want);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(7) != 0), ($urandom_range(3) == 0), ($urandom_range(7) == 0),
                  ($urandom_range(3) != 0), 8'($urandom), 8'($urandom));
            for (int u = 0; u < NI; u++) begin
                checks++;
                if ({md[u], ms[u], mv[u]} !== {expv[u].d, expv[u].s, expv[u].v}) begin
                    errors++;
                    $display("FAIL random u%0d i%0d: got d=%0d s=%0b v=%0b want d=%0d s=%0b v=%0b",
                             u, i, md[u], ms[u], mv[u], $signed(expv[u].d), expv[u].s, expv[u].v);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_signed_unsigned();
        test_unsigned_shift();
        test_valid_gap();
        test_clear();
        test_cke_and_reset();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
